// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared definitions for the cs147sec05 sequencer.
//   - state_t        : 3-bit binary sequencer state (FETCH=0 .. WB=4)
//   - opcode / funct : instruction field codes
//   - ALU op codes and datapath selector encodings
//   - ctrl_fields_t  : named view of the control word, packed by pack_ctrl()
//   - r_alu_op / i_alu_op : ALU operation implied by an R-type funct or an
//     I-type opcode (ALU_NONE when the instruction does not use the ALU in EXE)
package control_unit_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXE    = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // Width of the control word produced by the decoder
    localparam int CTRL_BITS = 32;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JMP   = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_PUSH  = 6'h1b;
    localparam logic [5:0] OP_POP   = 6'h1c;
    localparam logic [5:0] OP_MULI  = 6'h1d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type functs
    localparam logic [5:0] FN_SLL = 6'h01;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;
    localparam logic [5:0] FN_MUL = 6'h2c;

    // ALU operations
    localparam logic [5:0] ALU_NONE = 6'd0;
    localparam logic [5:0] ALU_ADD  = 6'd1;
    localparam logic [5:0] ALU_SUB  = 6'd2;
    localparam logic [5:0] ALU_MUL  = 6'd3;
    localparam logic [5:0] ALU_SRL  = 6'd4;
    localparam logic [5:0] ALU_SLL  = 6'd5;
    localparam logic [5:0] ALU_AND  = 6'd6;
    localparam logic [5:0] ALU_OR   = 6'd7;
    localparam logic [5:0] ALU_NOR  = 6'd8;
    localparam logic [5:0] ALU_SLT  = 6'd9;

    // Datapath selector encodings
    localparam logic [1:0] PC_SEL_NEXT   = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_REG    = 2'b10;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b11;
    localparam logic [1:0] WA_RD         = 2'b00;
    localparam logic [1:0] WA_RT         = 2'b01;
    localparam logic [1:0] WA_R31        = 2'b10;
    localparam logic [1:0] WA_R29        = 2'b11;
    localparam logic [1:0] WD_ALU        = 2'b00;
    localparam logic [1:0] WD_MEM        = 2'b01;
    localparam logic [1:0] WD_PC1        = 2'b10;
    localparam logic [1:0] WD_IMM        = 2'b11;
    localparam logic       OP1_R1        = 1'b0;
    localparam logic       OP1_SP        = 1'b1;
    localparam logic [1:0] OP2_R2        = 2'b00;
    localparam logic [1:0] OP2_SEXT      = 2'b01;
    localparam logic [1:0] OP2_ZEXT      = 2'b10;
    localparam logic [1:0] OP2_ONE       = 2'b11;
    localparam logic [1:0] MA_PC         = 2'b00;
    localparam logic [1:0] MA_ALU        = 2'b01;
    localparam logic [1:0] MA_SP         = 2'b10;
    localparam logic       MD_R2         = 1'b0;
    localparam logic       MD_R1         = 1'b1;

    typedef struct packed {
        logic       pc_load;
        logic [1:0] pc_sel;
        logic       ir_load;
        logic       reg_r;
        logic       reg_w;
        logic [1:0] wa_sel;
        logic [1:0] wd_sel;
        logic       op1_sel;
        logic [1:0] op2_sel;
        logic [5:0] alu_op;
        logic [1:0] ma_sel;
        logic       md_sel;
        logic       sp_load;
    } ctrl_fields_t;

    // Place each named field at its bit position; bit 4 and bits 31:24 stay 0
    function automatic logic [CTRL_BITS-1:0] pack_ctrl(input ctrl_fields_t f);
        logic [CTRL_BITS-1:0] w;
        w        = '0;
        w[0]     = f.pc_load;
        w[2:1]   = f.pc_sel;
        w[3]     = f.ir_load;
        w[5]     = f.reg_r;
        w[6]     = f.reg_w;
        w[8:7]   = f.wa_sel;
        w[10:9]  = f.wd_sel;
        w[11]    = f.op1_sel;
        w[13:12] = f.op2_sel;
        w[19:14] = f.alu_op;
        w[21:20] = f.ma_sel;
        w[22]    = f.md_sel;
        w[23]    = f.sp_load;
        return w;
    endfunction

    // jr is deliberately absent: it uses no ALU operation
    function automatic logic [5:0] r_alu_op(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_MUL:  return ALU_MUL;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_NOR:  return ALU_NOR;
            FN_SLT:  return ALU_SLT;
            FN_SLL:  return ALU_SLL;
            FN_SRL:  return ALU_SRL;
            default: return ALU_NONE;
        endcase
    endfunction

    // lw/sw compute their address with add; branches compare with sub
    function automatic logic [5:0] i_alu_op(input logic [5:0] opcode);
        case (opcode)
            OP_ADDI, OP_LW, OP_SW: return ALU_ADD;
            OP_MULI:               return ALU_MUL;
            OP_ANDI:               return ALU_AND;
            OP_ORI:                return ALU_OR;
            OP_SLTI:               return ALU_SLT;
            OP_BEQ, OP_BNE:        return ALU_SUB;
            default:               return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_ctrl_decode.sv
// ctrl_decode: combinational map (state, opcode, funct, zero) -> control word
// and memory strobes for the cs147sec05 sequencer.
//   state     in  state_t : current sequencer state (5..7 give all-zero outputs)
//   opcode    in  6       : INSTRUCTION[31:26]
//   funct     in  6       : INSTRUCTION[5:0]
//   zero      in  1       : ALU zero flag, used only for branches in WB
//   ctrl_word out 32      : datapath control word
//   read      out 1       : memory read strobe
//   write     out 1       : memory write strobe
module ctrl_decode
    import control_unit_pkg::*;
(
    input  state_t                 state,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   zero,
    output logic [CTRL_BITS-1:0]   ctrl_word,
    output logic                   read,
    output logic                   write
);

    ctrl_fields_t f;
    logic [5:0]   r_op;
    logic [5:0]   i_op;
    logic         is_rtype;

    always_comb begin
        f        = '0;
        read     = 1'b0;
        write    = 1'b0;
        r_op     = r_alu_op(funct);
        i_op     = i_alu_op(opcode);
        is_rtype = (opcode == OP_RTYPE);

        case (state)
            ST_FETCH: begin
                read      = 1'b1;
                f.ma_sel  = MA_PC;
                f.ir_load = 1'b1;
            end

            ST_DECODE: f.reg_r = 1'b1;

            ST_EXE: begin
                if (is_rtype) begin
                    if (r_op != ALU_NONE) begin
                        f.alu_op = r_op;
                        // Shift amount reaches the ALU through the immediate path
                        f.op2_sel = (funct == FN_SLL || funct == FN_SRL) ? OP2_SEXT : OP2_R2;
                    end
                end else if (i_op != ALU_NONE) begin
                    f.alu_op = i_op;
                    case (opcode)
                        OP_BEQ, OP_BNE:  f.op2_sel = OP2_R2;
                        OP_ANDI, OP_ORI: f.op2_sel = OP2_ZEXT;
                        default:         f.op2_sel = OP2_SEXT;
                    endcase
                end
            end

            ST_MEM: begin
                case (opcode)
                    OP_LW: begin
                        read     = 1'b1;
                        f.ma_sel = MA_ALU;
                    end
                    OP_SW: begin
                        write    = 1'b1;
                        f.ma_sel = MA_ALU;
                        f.md_sel = MD_R2;
                    end
                    OP_PUSH: begin
                        write    = 1'b1;
                        f.ma_sel = MA_SP;
                        f.md_sel = MD_R1;
                    end
                    OP_POP: begin
                        // Pop reads from sp+1, formed by the ALU this cycle
                        f.op1_sel = OP1_SP;
                        f.op2_sel = OP2_ONE;
                        f.alu_op  = ALU_ADD;
                        read      = 1'b1;
                        f.ma_sel  = MA_ALU;
                    end
                    default: ;
                endcase
            end

            ST_WB: begin
                f.pc_load = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            f.pc_sel = PC_SEL_REG;
                        end else if (r_op != ALU_NONE) begin
                            f.reg_w  = 1'b1;
                            f.wa_sel = WA_RD;
                            f.wd_sel = WD_ALU;
                        end
                    end
                    OP_ADDI, OP_MULI, OP_ANDI, OP_ORI, OP_SLTI: begin
                        f.reg_w  = 1'b1;
                        f.wa_sel = WA_RT;
                        f.wd_sel = WD_ALU;
                    end
                    OP_LW: begin
                        f.reg_w  = 1'b1;
                        f.wa_sel = WA_RT;
                        f.wd_sel = WD_MEM;
                    end
                    OP_LUI: begin
                        f.reg_w  = 1'b1;
                        f.wa_sel = WA_RT;
                        f.wd_sel = WD_IMM;
                    end
                    OP_BEQ: if (zero)  f.pc_sel = PC_SEL_BRANCH;
                    OP_BNE: if (!zero) f.pc_sel = PC_SEL_BRANCH;
                    OP_JMP: f.pc_sel = PC_SEL_JUMP;
                    OP_JAL: begin
                        f.pc_sel = PC_SEL_JUMP;
                        f.reg_w  = 1'b1;
                        f.wa_sel = WA_R31;
                        f.wd_sel = WD_PC1;
                    end
                    OP_PUSH: begin
                        f.sp_load = 1'b1;
                        f.op1_sel = OP1_SP;
                        f.op2_sel = OP2_ONE;
                        f.alu_op  = ALU_SUB;
                    end
                    OP_POP: begin
                        f.reg_w   = 1'b1;
                        f.wa_sel  = WA_RT;
                        f.wd_sel  = WD_MEM;
                        f.sp_load = 1'b1;
                        f.op1_sel = OP1_SP;
                        f.op2_sel = OP2_ONE;
                        f.alu_op  = ALU_ADD;
                    end
                    default: ;
                endcase
            end

            default: ;
        endcase

        ctrl_word = pack_ctrl(f);
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: five-state instruction sequencer for the cs147sec05 processor.
// Steps FETCH -> DECODE -> EXE -> MEM -> WB -> FETCH unconditionally and
// drives the datapath control word and memory strobes from the current state
// and the instruction register.
//   CLK         in  1      : clock, rising edge
//   RST         in  1      : asynchronous active-high reset (forces FETCH,
//                            holds all outputs at 0 while asserted)
//   INSTRUCTION in  32     : instruction register contents
//   ZERO        in  1      : ALU zero flag
//   CTRL        out CTRL_W : datapath control word
//   READ        out 1      : memory read strobe
//   WRITE       out 1      : memory write strobe
module control_unit
    import control_unit_pkg::*;
#(
    parameter int CTRL_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       INSTRUCTION,
    input  logic              ZERO,
    output logic [CTRL_W-1:0] CTRL,
    output logic              READ,
    output logic              WRITE
);

    state_t                 state_reg;
    state_t                 state_next;
    logic [CTRL_BITS-1:0]   dec_ctrl;
    logic                   dec_read;
    logic                   dec_write;
    logic [CTRL_BITS-1:0]   ctrl_gated;

    // Register and immediate fields are consumed by the datapath, not here
    logic unused_instr_bits;
    assign unused_instr_bits = ^INSTRUCTION[25:6];

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; unreachable encodings recover to FETCH
    always_comb begin
        state_next = ST_FETCH;
        case (state_reg)
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: state_next = ST_EXE;
            ST_EXE:    state_next = ST_MEM;
            ST_MEM:    state_next = ST_WB;
            ST_WB:     state_next = ST_FETCH;
            default:   state_next = ST_FETCH;
        endcase
    end

    ctrl_decode u_decode (
        .state     (state_reg),
        .opcode    (INSTRUCTION[31:26]),
        .funct     (INSTRUCTION[5:0]),
        .zero      (ZERO),
        .ctrl_word (dec_ctrl),
        .read      (dec_read),
        .write     (dec_write)
    );

    // Output logic: the state register already sits in FETCH during reset, so
    // the FETCH strobes must be masked until RST drops.
    always_comb begin
        ctrl_gated = RST ? '0 : dec_ctrl;
        READ       = RST ? 1'b0 : dec_read;
        WRITE      = RST ? 1'b0 : dec_write;
    end

    // Fit the decoded word to CTRL_W, zero-padding any extra high bits
    for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_bit
        if (gi < CTRL_BITS) begin : g_used
            assign CTRL[gi] = ctrl_gated[gi];
        end else begin : g_pad
            assign CTRL[gi] = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized self-checking bench for control_unit.
// A behavioural model derives the expected control word for each cycle of an
// instruction from the opcode/funct rules; directed instructions from the
// test plan run first, then random instructions with occasional aborts.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        zero;
    logic [31:0] ctrl;
    logic        read;
    logic        write;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_unit #(.CTRL_W(32)) dut (
        .CLK         (clk),
        .RST         (rst),
        .INSTRUCTION (instruction),
        .ZERO        (zero),
        .CTRL        (ctrl),
        .READ        (read),
        .WRITE       (write)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Expected {READ, WRITE, CTRL} for cycle 'phase' (0=fetch .. 4=write-back)
    function automatic logic [33:0] model(input int phase, input logic [31:0] ins, input logic z);
        logic [5:0] op;
        logic [5:0] fn;
        int r_alu, i_alu, alu, o1, o2, ma, md, pcs, wa, wd;
        int pcl, irl, rr, rw, spl, rd, wr;
        int is_r, sum;
        op = ins[31:26];
        fn = ins[5:0];
        is_r = (op == 6'h00) ? 1 : 0;

        r_alu = 0;
        case (fn)
            6'h20: r_alu = 1;  6'h22: r_alu = 2;  6'h2c: r_alu = 3;
            6'h02: r_alu = 4;  6'h01: r_alu = 5;  6'h24: r_alu = 6;
            6'h25: r_alu = 7;  6'h27: r_alu = 8;  6'h2a: r_alu = 9;
            default: r_alu = 0;
        endcase
        i_alu = 0;
        case (op)
            6'h08, 6'h23, 6'h2b: i_alu = 1;
            6'h1d: i_alu = 3;
            6'h0c: i_alu = 6;
            6'h0d: i_alu = 7;
            6'h0a: i_alu = 9;
            6'h04, 6'h05: i_alu = 2;
            default: i_alu = 0;
        endcase

        alu = 0; o1 = 0; o2 = 0; ma = 0; md = 0; pcs = 0; wa = 0; wd = 0;
        pcl = 0; irl = 0; rr = 0; rw = 0; spl = 0; rd = 0; wr = 0;

        case (phase)
            0: begin rd = 1; irl = 1; end
            1: rr = 1;
            2: begin
                if (is_r == 1 && r_alu != 0) begin
                    alu = r_alu;
                    o2 = (fn == 6'h01 || fn == 6'h02) ? 1 : 0;
                end else if (is_r == 0 && i_alu != 0) begin
                    alu = i_alu;
                    if (op == 6'h04 || op == 6'h05) o2 = 0;
                    else if (op == 6'h0c || op == 6'h0d) o2 = 2;
                    else o2 = 1;
                end
            end
            3: begin
                if (op == 6'h23) begin rd = 1; ma = 1; end
                if (op == 6'h2b) begin wr = 1; ma = 1; md = 0; end
                if (op == 6'h1b) begin wr = 1; ma = 2; md = 1; end
                if (op == 6'h1c) begin o1 = 1; o2 = 3; alu = 1; rd = 1; ma = 1; end
            end
            4: begin
                pcl = 1;
                if ((op == 6'h04 && z) || (op == 6'h05 && !z)) pcs = 1;
                if (is_r == 1 && fn == 6'h08) pcs = 2;
                if (op == 6'h02 || op == 6'h03) pcs = 3;
                if (is_r == 1 && r_alu != 0) begin rw = 1; wa = 0; wd = 0; end
                if (op == 6'h08 || op == 6'h1d || op == 6'h0c || op == 6'h0d || op == 6'h0a) begin
                    rw = 1; wa = 1; wd = 0;
                end
                if (op == 6'h23) begin rw = 1; wa = 1; wd = 1; end
                if (op == 6'h0f) begin rw = 1; wa = 1; wd = 3; end
                if (op == 6'h03) begin rw = 1; wa = 2; wd = 2; end
                if (op == 6'h1c) begin rw = 1; wa = 1; wd = 1; spl = 1; o1 = 1; o2 = 3; alu = 1; end
                if (op == 6'h1b) begin spl = 1; o1 = 1; o2 = 3; alu = 2; end
            end
            default: ;
        endcase

        sum = pcl + (pcs << 1) + (irl << 3) + (rr << 5) + (rw << 6) + (wa << 7) + (wd << 9)
            + (o1 << 11) + (o2 << 12) + (alu << 14) + (ma << 20) + (md << 22) + (spl << 23);
        return {rd[0], wr[0], 32'(sum)};
    endfunction

    task automatic check_phase(input int phase, input logic [31:0] ins, input logic z, input string name);
        logic [33:0] e;
        e = model(phase, ins, z);
        check($sformatf("%s ph%0d ctrl", name, phase), ctrl, e[31:0]);
        check($sformatf("%s ph%0d read", name, phase), {31'b0, read}, {31'b0, e[33]});
        check($sformatf("%s ph%0d write", name, phase), {31'b0, write}, {31'b0, e[32]});
    endtask

    task automatic check_idle(input string name);
        check($sformatf("%s ctrl", name), ctrl, 32'h0);
        check($sformatf("%s read", name), {31'b0, read}, 32'h0);
        check($sformatf("%s write", name), {31'b0, write}, 32'h0);
    endtask

    // Entry/exit: 1 time unit after the rising edge that starts a FETCH cycle.
    // abort_at in 1..4 asserts RST during that phase; 5 runs to completion.
    task automatic run_instr(input logic [31:0] ins, input logic z, input int abort_at, input string name);
        int err0;
        err0 = errors;
        instruction = $urandom();       // don't-care during FETCH
        zero = 1'($urandom_range(0, 1));
        #1 check_phase(0, ins, z, name);
        #1;
        instruction = ins;
        zero = z;
        for (int p = 1; p < 5; p++) begin
            @(posedge clk);
            #2 check_phase(p, ins, z, name);
            if (p == abort_at) begin
                #2 rst = 1'b1;
                #2 check_idle($sformatf("%s abort ph%0d", name, p));
                @(posedge clk);
                #1 check_idle($sformatf("%s abort held", name));
                rst = 1'b0;
                $display("instr %08h zero %0b aborted in phase %0d, new errors %0d",
                         ins, z, p, errors - err0);
                return;
            end
        end
        @(posedge clk);
        #1;
        $display("instr %08h zero %0b completed, new errors %0d", ins, z, errors - err0);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [5:0]  ops [16] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0a,
                                  6'h0c, 6'h0d, 6'h0f, 6'h1b, 6'h1c, 6'h1d, 6'h23, 6'h2b};
        logic [5:0]  fns [10] = '{6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h01,
                                  6'h02, 6'h08};
        logic [31:0] ins;
        logic [5:0]  op;
        ins = $urandom();
        op = ($urandom_range(0, 9) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 15)];
        ins[31:26] = op;
        if (op == 6'h00 && $urandom_range(0, 7) != 0) ins[5:0] = fns[$urandom_range(0, 9)];
        return ins;
    endfunction

    initial begin
        logic [31:0] ins;
        logic [31:0] bad_op;
        rst = 1'b1;
        instruction = 32'h0;
        zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_idle("reset hold");
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed cases
        run_instr(32'h00432020, 1'b0, 5, "add");
        run_instr(32'h00432020, 1'b1, 2, "add abort exe");
        run_instr(32'h00432020, 1'b0, 5, "add after abort");
        run_instr(32'h8C220004, 1'b0, 5, "lw");
        run_instr(32'h10220003, 1'b1, 5, "beq taken");
        run_instr(32'h10220003, 1'b0, 5, "beq not taken");
        run_instr(32'h14220003, 1'b0, 5, "bne taken");
        run_instr(32'h0C000010, 1'b0, 5, "jal");
        bad_op = $urandom();
        bad_op[31:26] = 6'h3f;
        run_instr(bad_op, 1'($urandom_range(0, 1)), 5, "unknown op");
        run_instr(32'h6C400000, 1'b0, 5, "push");
        run_instr(32'h70020000, 1'b0, 5, "pop");

        // Random instructions, roughly one in eight aborted by reset
        for (int n = 0; n < 120; n++) begin
            ins = gen_instr();
            run_instr(ins, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 5,
                      $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencer for the 32-bit cs147sec05 processor. It drives the datapath's `CTRL` word and the memory `READ`/`WRITE` strobes. It runs a fixed five-state cycle per instruction: fetch, decode, execute, memory, write-back. It decodes `INSTRUCTION` and the `ZERO` flag from the datapath, and sits beside the datapath in the processor top level.

## Interface
- `CTRL_W`, default 32: control-word width. It matches `` `CTRL_WIDTH_INDEX_LIMIT ``+1.
- `CLK`  in  1: clock. All state updates on the rising edge.
- `RST`  in  1: reset, asynchronous, active-high.
- `INSTRUCTION`  in  32: instruction register contents from the datapath.
- `ZERO`  in  1: ALU zero flag from the datapath.
- `CTRL`  out  `CTRL_W`: datapath control word.
- `READ`  out  1: memory read strobe.
- `WRITE`  out  1: memory write strobe.

## Operation
- States: FETCH → DECODE → EXE → MEM → WB → FETCH, unconditional. Every instruction takes exactly 5 cycles.
- Outputs are combinational from the registered state and `INSTRUCTION`. All unnamed control fields are 0.
- CTRL fields:
  - PC_LOAD[0]
  - PC_SEL[2:1]: 00 pc+1, 01 pc+1+sext(imm), 10 r1, 11 {pc[31:26],addr26}
  - IR_LOAD[3]
  - REG_R[5], REG_W[6]
  - WA_SEL[8:7]: 00 rd, 01 rt, 10 r31, 11 r29
  - WD_SEL[10:9]: 00 alu, 01 mem, 10 pc+1, 11 {imm,16'h0}
  - OP1_SEL[11]: 0 r1, 1 sp
  - OP2_SEL[13:12]: 00 r2, 01 sext imm, 10 zext imm, 11 const 1
  - ALU_OP[19:14]: 1 add, 2 sub, 3 mul, 4 srl, 5 sll, 6 and, 7 or, 8 nor, 9 slt
  - MA_SEL[21:20]: 00 pc, 01 alu, 10 sp
  - MD_SEL[22]: 0 r2, 1 r1
  - SP_LOAD[23]
- FETCH: READ=1, MA_SEL=pc, IR_LOAD=1.
- DECODE: REG_R=1.
- EXE: ALU_OP/OP*_SEL per opcode.
  - R-type funct: 0x20 add, 0x22 sub, 0x2c mul, 0x24 and, 0x25 or, 0x27 nor, 0x2a slt, 0x01 sll, 0x02 srl, 0x08 jr. Shifts use OP2_SEL=const shamt path, decided as 01 with shamt in the imm low bits.
  - I-type: addi 0x08, muli 0x1d, andi 0x0c, ori 0x0d, slti 0x0a, lw 0x23, sw 0x2b use sext imm, except andi/ori, which use zext. beq 0x04 and bne 0x05 use sub r1,r2.
- MEM:
  - lw: READ=1, MA_SEL=alu.
  - sw: WRITE=1, MA_SEL=alu, MD_SEL=r2.
  - push 0x1b: WRITE=1, MA_SEL=sp, MD_SEL=r1.
  - pop 0x1c: OP1_SEL=sp, OP2_SEL=const1, ALU add, READ=1, MA_SEL=alu.
  - All other opcodes: READ=WRITE=0.
- WB: PC_LOAD=1 always.
  - PC_SEL: beq with ZERO=1 or bne with ZERO=0 → 01; jr → 10; jmp 0x02/jal 0x03 → 11; otherwise 00.
  - REG_W=1 for R-type except jr: WA=rd, WD=alu.
  - REG_W=1 for addi/muli/andi/ori/slti: WA=rt, WD=alu.
  - REG_W=1 for lw: WA=rt, WD=mem.
  - REG_W=1 for lui 0x0f: WA=rt, WD=imm.
  - REG_W=1 for jal: WA=r31, WD=pc+1.
  - REG_W=1 for pop: WA=rt, WD=mem.
  - push: SP_LOAD=1, with ALU doing sp−1 in WB (OP1=sp, OP2=const1, sub).
  - pop: SP_LOAD=1 with sp+1.
- Unknown opcode or funct: NOP, meaning only PC_LOAD with pc+1 in WB. No error flag.

## Timing
- RST=1: state=FETCH immediately, without waiting for CLK. While RST is held, CTRL=0 and READ=WRITE=0.
- First FETCH outputs appear in the cycle after RST deasserts.
- Reset mid-instruction aborts it. No write-back occurs, and PC is untouched by this block.
- `INSTRUCTION` is valid from DECODE through WB. Its value during FETCH is ignored.
- `ZERO` is sampled combinationally in WB. The datapath holds its ALU operands stable EXE→WB.
- One instruction per 5 clocks. There is no stall input and no pipelining.

## Structure
- Field bit positions, ALU op codes, opcodes/functs and state encodings go in the shared `prj_definition.v` `` `define`` set.
- State register: 3 bits, binary, FETCH=0…WB=4. Encodings 5–7 go to FETCH on the next clock.
- One natural sub-module: `ctrl_decode`, combinational, mapping (state, INSTRUCTION, ZERO) → {CTRL, READ, WRITE}.

## Test plan
- Reset: assert RST mid-EXE → state=FETCH without CLK, CTRL=0. Release → next cycle READ=1, IR_LOAD=1, MA_SEL=00.
- add r4,r2,r3 (0x00432020) → EXE ALU_OP=1, OP2_SEL=00. WB REG_W=1, WA_SEL=00, WD_SEL=00, PC_SEL=00. 5 clocks total.
- lw r2,4(r1) (0x8C220004) → MEM READ=1, MA_SEL=01. WB WA_SEL=01, WD_SEL=01.
- beq r1,r2,3 (0x10220003):
  - ZERO=1 → WB PC_SEL=01.
  - ZERO=0 → PC_SEL=00, REG_W=0.
- jal 0x10 (0x0C000010) → WB PC_SEL=11, REG_W=1, WA_SEL=10, WD_SEL=10.
- Opcode 0x3f → all 5 states: READ/WRITE only in FETCH, REG_W=0, WB PC_LOAD=1 with PC_SEL=00.
